// File: rtl/huff_pkg.sv
// Shared constants and helpers for the canonical Huffman decoder.
package huff_pkg;

    localparam logic CFG_SEL_COUNT = 1'b0;
    localparam logic CFG_SEL_SYM   = 1'b1;

    // Ceiling log2, used to size indices and counters from the parameters.
    function automatic int unsigned clog2(input int unsigned v);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 31; i++) begin
            if ((32'd1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/huff_code_table.sv
// Run-time loadable code table: per-length code counts and canonical-order symbols.
module huff_code_table
    import huff_pkg::*;
#(
    parameter int unsigned SYM_W    = 3,
    parameter int unsigned MAX_LEN  = 4,
    parameter int unsigned NUM_SYMS = 6,
    localparam int unsigned IDX_W   = clog2(NUM_SYMS),
    localparam int unsigned CNT_W   = clog2(NUM_SYMS + 1),
    localparam int unsigned LEN_W   = clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [SYM_W-1:0] cfg_data,
    input  logic [LEN_W-1:0] rd_len,
    input  logic [IDX_W-1:0] rd_idx,
    output logic [CNT_W-1:0] cnt_c,
    output logic [SYM_W-1:0] sym_c
);

    logic [CNT_W-1:0] count  [MAX_LEN];
    logic [SYM_W-1:0] symtab [NUM_SYMS];

    // Out-of-range addresses match no entry and are silently ignored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < MAX_LEN; i++) count[i] <= '0;
            for (int unsigned i = 0; i < NUM_SYMS; i++) symtab[i] <= '0;
        end else if (cfg_we) begin
            if (cfg_sel == CFG_SEL_COUNT) begin
                for (int unsigned i = 0; i < MAX_LEN; i++) begin
                    if (32'(cfg_addr) == i) count[i] <= CNT_W'(cfg_data);
                end
            end else begin
                for (int unsigned i = 0; i < NUM_SYMS; i++) begin
                    if (32'(cfg_addr) == i) symtab[i] <= cfg_data;
                end
            end
        end
    end

    always_comb begin
        cnt_c = '0;
        for (int unsigned i = 0; i < MAX_LEN; i++) begin
            if (32'(rd_len) == i + 1) cnt_c = count[i];
        end
    end

    always_comb begin
        sym_c = '0;
        for (int unsigned i = 0; i < NUM_SYMS; i++) begin
            if (32'(rd_idx) == i) sym_c = symtab[i];
        end
    end

endmodule

// File: rtl/canonical_huffman_decoder.sv
// Bit-serial canonical Huffman decoder with a run-time loadable table.
// One code bit per accepted beat; emits a symbol or a one-cycle err on an unmatched code.
module canonical_huffman_decoder
    import huff_pkg::*;
#(
    parameter int unsigned SYM_W    = 3,
    parameter int unsigned MAX_LEN  = 4,
    parameter int unsigned NUM_SYMS = 6,
    localparam int unsigned IDX_W   = clog2(NUM_SYMS),
    localparam int unsigned CNT_W   = clog2(NUM_SYMS + 1),
    localparam int unsigned LEN_W   = clog2(MAX_LEN + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             x,
    input  logic             x_valid,
    output logic             x_ready,
    output logic [SYM_W-1:0] y,
    output logic             y_valid,
    input  logic             y_ready,
    output logic             err,
    input  logic             cfg_we,
    input  logic             cfg_sel,
    input  logic [IDX_W-1:0] cfg_addr,
    input  logic [SYM_W-1:0] cfg_data
);

    localparam int unsigned CW = MAX_LEN + 1;

    logic [LEN_W-1:0] len, len_n;
    logic [CW-1:0]    code, code_n, first, first_n;
    logic [IDX_W-1:0] index, index_n;
    logic [SYM_W-1:0] y_n;
    logic             y_valid_n, err_n;

    logic [CW-1:0]    c_c, diff_c;
    logic [IDX_W-1:0] sym_idx_c;
    logic [CNT_W-1:0] cnt_c;
    logic [SYM_W-1:0] sym_c;
    logic             hit_c, take_c;

    huff_code_table #(
        .SYM_W    (SYM_W),
        .MAX_LEN  (MAX_LEN),
        .NUM_SYMS (NUM_SYMS)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data),
        .rd_len   (len),
        .rd_idx   (sym_idx_c),
        .cnt_c    (cnt_c),
        .sym_c    (sym_c)
    );

    assign x_ready = !y_valid || y_ready;
    assign take_c  = x_valid && x_ready;

    // Candidate code and its offset into the current length's code range.
    always_comb begin
        c_c       = {code[CW-2:0], x};
        diff_c    = c_c - first;
        hit_c     = (c_c >= first) && (32'(diff_c) < 32'(cnt_c));
        sym_idx_c = index + IDX_W'(diff_c);
    end

    always_comb begin
        len_n     = len;
        code_n    = code;
        first_n   = first;
        index_n   = index;
        y_n       = y;
        y_valid_n = y_valid;
        err_n     = 1'b0;

        if (y_valid && y_ready) y_valid_n = 1'b0;

        if (cfg_we || (take_c && (hit_c || len == LEN_W'(MAX_LEN)))) begin
            len_n   = LEN_W'(1);
            code_n  = '0;
            first_n = '0;
            index_n = '0;
        end else if (take_c) begin
            len_n   = len + LEN_W'(1);
            code_n  = c_c;
            index_n = index + IDX_W'(cnt_c);
            first_n = (first + CW'(cnt_c)) << 1;
        end

        // A bit arriving alongside a table write is dropped.
        if (!cfg_we && take_c) begin
            if (hit_c) begin
                y_n       = sym_c;
                y_valid_n = 1'b1;
            end else if (len == LEN_W'(MAX_LEN)) begin
                err_n = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            len     <= LEN_W'(1);
            code    <= '0;
            first   <= '0;
            index   <= '0;
            y       <= '0;
            y_valid <= 1'b0;
            err     <= 1'b0;
        end else begin
            len     <= len_n;
            code    <= code_n;
            first   <= first_n;
            index   <= index_n;
            y       <= y_n;
            y_valid <= y_valid_n;
            err     <= err_n;
        end
    end

endmodule

// File: tb/tb_canonical_huffman_decoder.sv
// Bench for canonical_huffman_decoder: codeword-list reference model checked every cycle,
// plus directed scenarios with literal expected symbol sequences.
module tb_canonical_huffman_decoder;

    localparam int SYM_W    = 3;
    localparam int MAX_LEN  = 4;
    localparam int NUM_SYMS = 6;
    localparam int CNT_W    = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       x = 1'b0, x_valid = 1'b0, y_ready = 1'b1;
    logic       x_ready, y_valid, err;
    logic [2:0] y;
    logic       cfg_we = 1'b0, cfg_sel = 1'b0;
    logic [2:0] cfg_addr = 3'd0, cfg_data = 3'd0;

    int checks = 0;
    int errors = 0;

    canonical_huffman_decoder dut (
        .clk      (clk),
        .reset    (reset),
        .x        (x),
        .x_valid  (x_valid),
        .x_ready  (x_ready),
        .y        (y),
        .y_valid  (y_valid),
        .y_ready  (y_ready),
        .err      (err),
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_addr (cfg_addr),
        .cfg_data (cfg_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    int mc [MAX_LEN];
    int ms [NUM_SYMS];
    bit exp_yv, exp_err, last_take;
    int exp_y, bl, bv;

    // Enumerate canonical codewords in order and look for (bl, bv).
    function automatic bit lookup(input int len_b, input int val_b, output int sym);
        int code, k;
        code = 0;
        k    = 0;
        sym  = 0;
        for (int l = 1; l <= MAX_LEN; l++) begin
            for (int j = 0; j < mc[l-1]; j++) begin
                if (l == len_b && code == val_b) begin
                    sym = ((k % 8) < NUM_SYMS) ? ms[k % 8] : 0;
                    return 1'b1;
                end
                code++;
                k++;
            end
            code = code * 2;
        end
        return 1'b0;
    endfunction

    always @(posedge clk or posedge reset) begin : model
        bit take;
        int s, a;
        if (reset) begin
            exp_yv = 0; exp_y = 0; exp_err = 0; bl = 0; bv = 0; last_take = 0;
            for (int i = 0; i < MAX_LEN; i++) mc[i] = 0;
            for (int i = 0; i < NUM_SYMS; i++) ms[i] = 0;
        end else begin
            take      = x_valid && (!exp_yv || y_ready);
            last_take = take && !cfg_we;
            exp_err   = 0;
            if (exp_yv && y_ready) exp_yv = 0;
            if (cfg_we) begin
                a = int'(cfg_addr);
                if (cfg_sel == 1'b0) begin
                    if (a < MAX_LEN) mc[a] = int'(cfg_data) % (1 << CNT_W);
                end else if (a < NUM_SYMS) begin
                    ms[a] = int'(cfg_data);
                end
                bl = 0; bv = 0;
            end else if (take) begin
                bl = bl + 1;
                bv = bv * 2 + int'(x);
                if (lookup(bl, bv, s)) begin
                    exp_y = s; exp_yv = 1; bl = 0; bv = 0;
                end else if (bl == MAX_LEN) begin
                    exp_err = 1; bl = 0; bv = 0;
                end
            end
        end
    end

    // Per-cycle comparison against the model.
    always begin
        @(posedge clk);
        #1;
        if (!reset) begin
            chk("y_valid", int'(y_valid), int'(exp_yv));
            chk("y", int'(y), exp_y);
            chk("err", int'(err), int'(exp_err));
            chk("x_ready", int'(x_ready), int'(!exp_yv || y_ready));
        end
    end

    // Record delivered symbols and err pulses for the directed literal checks.
    int got[$];
    int nerr;
    always @(posedge clk) begin
        if (!reset) begin
            if (y_valid && y_ready) got.push_back(int'(y));
            if (err) nerr++;
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic cyc(input bit xv, input bit xb, input bit yr);
        @(negedge clk);
        x_valid = xv; x = xb; y_ready = yr; cfg_we = 1'b0;
    endtask

    task automatic cfg_wr(input bit sel, input int a, input int d);
        @(negedge clk);
        cfg_we = 1'b1; cfg_sel = sel; cfg_addr = 3'(a); cfg_data = 3'(d);
        x_valid = 1'b0; y_ready = 1'b1;
    endtask

    task automatic send(input int v, input int n);
        for (int i = n - 1; i >= 0; i--) cyc(1'b1, 1'(v >> i), 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) cyc(1'b0, 1'b0, 1'b1);
    endtask

    task automatic load_table();
        cfg_wr(1'b0, 0, 1); cfg_wr(1'b0, 1, 0); cfg_wr(1'b0, 2, 3); cfg_wr(1'b0, 3, 2);
        for (int i = 0; i < NUM_SYMS; i++) cfg_wr(1'b1, i, i + 1);
        idle(2);
    endtask

    task automatic clear_log();
        got.delete();
        nerr = 0;
    endtask

    int code_len [6] = '{1, 3, 3, 3, 4, 4};
    int code_val [6] = '{0, 4, 5, 6, 14, 15};

    initial begin
        bit q[$];
        int k, a, d;

        repeat (3) @(negedge clk);
        #1;
        chk("reset_y", int'(y), 0);
        chk("reset_y_valid", int'(y_valid), 0);
        chk("reset_err", int'(err), 0);
        chk("reset_x_ready", int'(x_ready), 1);
        @(negedge clk);
        reset = 1'b0;
        load_table();

        // Every codeword once, consumer always ready.
        clear_log();
        send(0, 1); send(4, 3); send(5, 3); send(6, 3); send(14, 4); send(15, 4);
        idle(3);
        chk("t1_count", got.size(), 6);
        for (int i = 0; i < 6 && i < got.size(); i++) chk("t1_sym", got[i], i + 1);
        chk("t1_err", nerr, 0);

        // Back-pressure: three 'A' codes while the consumer stalls.
        clear_log();
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        #1 chk("t2_xready_block", int'(x_ready), 0);
        chk("t2_y_held", int'(y), 1);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b1);
        cyc(1'b1, 1'b0, 1'b1);
        idle(3);
        chk("t2_count", got.size(), 3);
        for (int i = 0; i < 3 && i < got.size(); i++) chk("t2_sym", got[i], 1);

        // Remove F; 1111 is now invalid.
        cfg_wr(1'b0, 3, 1);
        idle(1);
        clear_log();
        send(15, 4);
        idle(3);
        chk("t3_err", nerr, 1);
        chk("t3_no_sym", got.size(), 0);
        send(0, 1);
        idle(2);
        chk("t3_recover", got.size() == 1 ? got[0] : -1, 1);
        cfg_wr(1'b0, 3, 2);

        // Out-of-range writes are ignored; a table write discards a partial code.
        cfg_wr(1'b0, 4, 7);
        cfg_wr(1'b1, 6, 7);
        cfg_wr(1'b1, 7, 0);
        idle(1);
        clear_log();
        send(3, 2);
        cfg_wr(1'b1, 0, 1);
        send(0, 1);
        idle(2);
        chk("t4_sym", got.size() == 1 ? got[0] : -1, 1);
        chk("t4_err", nerr, 0);
        send(15, 4);
        idle(2);
        chk("t4_F_intact", got.size() == 2 ? got[1] : -1, 6);

        // Reset mid-code clears state and tables.
        send(3, 2);
        @(negedge clk);
        x_valid = 1'b0;
        reset   = 1'b1;
        #1;
        chk("t5_y_valid", int'(y_valid), 0);
        chk("t5_y", int'(y), 0);
        @(negedge clk);
        reset = 1'b0;
        clear_log();
        send(0, 4);
        idle(3);
        chk("t5_err", nerr, 1);
        chk("t5_no_sym", got.size(), 0);
        load_table();

        // Random codeword stream with random handshakes and occasional table rewrites.
        idle(1);
        for (int n = 0; n < 3000; n++) begin
            @(negedge clk);
            if (last_take && q.size() > 0) void'(q.pop_front());
            if (q.size() == 0) begin
                k = $urandom_range(0, 5);
                for (int i = code_len[k] - 1; i >= 0; i--) q.push_back(1'((code_val[k] >> i) & 1));
            end
            y_ready = 1'($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 99) == 0) begin
                cfg_we  = 1'b1;
                cfg_sel = 1'($urandom_range(0, 1));
                a       = $urandom_range(0, 7);
                if (cfg_sel == 1'b0) d = (a < MAX_LEN) ? mc[a] : $urandom_range(0, 7);
                else d = (a < NUM_SYMS) ? ms[a] : $urandom_range(0, 7);
                cfg_addr = 3'(a);
                cfg_data = 3'(d);
            end else begin
                cfg_we = 1'b0;
            end
            x_valid = 1'($urandom_range(0, 3) != 0);
            x       = q[0];
        end
        idle(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
